// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one full-adder
// bit per clock, with a registered carry. Results appear with a one-cycle
// done pulse and hold until the next accepted start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_sum;
    logic             carry_next;

    // One full-adder slice operating on the current LSBs and the stored carry
    always_comb begin
        bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    // Control FSM plus datapath registers; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        sum   <= '0;
                        co    <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= {bit_sum, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        co    <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    always #5 clk = ~clk;

    // Launch one addition and wait (bounded) for its done pulse.
    // Operand inputs are scrambled right after the accept edge.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          output logic [7:0] r_sum, output logic r_co,
                          output int busy_cycles, output logic [7:0] sum_at_accept,
                          output logic timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        r_sum       = '0;
        r_co        = 1'b0;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~op_a; b = ~op_b;
        sum_at_accept = sum;
        if (busy) busy_cycles++;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                r_sum = sum; r_co = co; timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, co, sum} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b co=%b sum=%h, expected all 0", busy, done, co, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] va [5] = '{8'h00, 8'h0F, 8'h5A, 8'hFF, 8'hFF};
        logic [7:0] vb [5] = '{8'h00, 8'h01, 8'hA5, 8'h01, 8'hFF};
        logic [8:0] ve [5] = '{9'h000, 9'h010, 9'h0FF, 9'h100, 9'h1FE};
        logic [7:0] r_sum, acc_sum;
        logic r_co, to;
        int bc;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], r_sum, r_co, bc, acc_sum, to);
            checks++;
            if (to) begin
                errors++;
                $display("[TB] FAIL basic_timeout[%0d]: got no done, expected done within 30 cycles", i);
                continue;
            end
            checks++;
            if ({r_co, r_sum} !== ve[i]) begin
                errors++;
                $display("[TB] FAIL basic_result[%0d] %h+%h: got %h, expected %h", i, va[i], vb[i], {r_co, r_sum}, ve[i]);
            end
            checks++;
            if (bc != 8) begin
                errors++;
                $display("[TB] FAIL basic_busy_cycles[%0d]: got %0d, expected 8", i, bc);
            end
            checks++;
            if (acc_sum !== 8'h00) begin
                errors++;
                $display("[TB] FAIL basic_sum_cleared[%0d]: got %h, expected 00", i, acc_sum);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_done_width[%0d]: got done=%b, expected 0", i, done);
            end
            @(negedge clk); @(negedge clk);
            checks++;
            if ({co, sum} !== ve[i]) begin
                errors++;
                $display("[TB] FAIL basic_hold[%0d]: got %h, expected %h", i, {co, sum}, ve[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int done_cnt = 0;
        int busy_cnt = 0;
        logic [8:0] res = '0;
        @(negedge clk);
        a = 8'h3C; b = 8'h21; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        for (int i = 1; i <= 16; i++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; res = {co, sum}; end
            if (i == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
            if (i == 4) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (res !== 9'h05D) begin
            errors++;
            $display("[TB] FAIL ignored_start_result: got %h, expected 05d", res);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL ignored_start_done_count: got %0d, expected 1", done_cnt);
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("[TB] FAIL ignored_start_busy_cycles: got %0d, expected 8", busy_cnt);
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] r_sum, acc_sum;
        logic r_co, to;
        int bc;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, co, sum} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL midop_reset: got busy=%b done=%b co=%b sum=%h, expected all 0", busy, done, co, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h80, 8'h80, r_sum, r_co, bc, acc_sum, to);
        checks++;
        if (to || {r_co, r_sum} !== 9'h100) begin
            errors++;
            $display("[TB] FAIL midop_after_reset: got timeout=%b result=%h, expected timeout=0 result=100", to, {r_co, r_sum});
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expv;
        int cyc = 0;
        int last_done = -1;
        int waited;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
        expv = {1'b0, a} + {1'b0, b};
        for (int op = 0; op < 200; op++) begin
            waited = 0;
            do begin
                @(negedge clk);
                cyc++; waited++;
            end while (!done && waited < 30);
            checks++;
            if (!done) begin
                errors++;
                $display("[TB] FAIL b2b_timeout[%0d]: got no done, expected done within 30 cycles", op);
                start = 1'b0;
                break;
            end
            checks++;
            if ({co, sum} !== expv) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d]: got %h, expected %h", op, {co, sum}, expv);
            end
            if (last_done >= 0) begin
                checks++;
                if (cyc - last_done != 10) begin
                    errors++;
                    $display("[TB] FAIL b2b_period[%0d]: got %0d, expected 10", op, cyc - last_done);
                end
            end
            last_done = cyc;
            if (op == 199) begin
                start = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom);
                expv = {1'b0, a} + {1'b0, b};
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
